// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the BIP accumulator datapath and the
// instruction decoder that drives it.
//   - Default widths of the accumulator/RAM data and of the operand field.
//   - Encodings of the sel_a / sel_b / operation control fields.
package bip_pkg;

    localparam int NB_DATA_DEF       = 16;
    localparam int NB_OPERAND_DEF    = 11;
    localparam int NB_SELECTOR_A_DEF = 2;

    // Accumulator source select
    typedef enum logic [1:0] {
        SEL_A_RAM  = 2'b00,
        SEL_A_IMM  = 2'b01,
        SEL_A_ALU  = 2'b10,
        SEL_A_HOLD = 2'b11
    } sel_a_e;

    // ALU operand B select
    localparam logic SEL_B_IMM = 1'b0;
    localparam logic SEL_B_RAM = 1'b1;

    // ALU operation
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/bip_alu.sv
// bip_alu: combinational add/subtract with signed-overflow detection.
// Ports:
//   i_a         : operand A (accumulator)
//   i_b         : operand B (RAM data or sign-extended immediate)
//   i_operation : OP_ADD = a + b, OP_SUB = a - b (both wrap)
//   o_result    : wrapped result
//   o_overflow  : signed overflow of the selected operation
module bip_alu
    import bip_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic               i_operation,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow
);

    logic sign_a;
    logic sign_b;
    logic sign_r;

    always_comb begin
        if (i_operation == OP_ADD) begin
            o_result = i_a + i_b;
        end else begin
            o_result = i_a - i_b;
        end

        sign_a = i_a[NB_DATA-1];
        sign_b = i_b[NB_DATA-1];
        sign_r = o_result[NB_DATA-1];

        // Add overflows when both operands share a sign the result lacks;
        // subtract overflows when operands differ and the result leaves A's sign.
        if (i_operation == OP_ADD) begin
            o_overflow = (sign_a == sign_b) && (sign_r != sign_a);
        end else begin
            o_overflow = (sign_a != sign_b) && (sign_r != sign_a);
        end
    end

endmodule

// File: rtl/bip_datapath.sv
// bip_datapath: accumulator datapath of the BIP processor.
// Ports:
//   i_clock     : system clock, rising edge
//   i_reset     : asynchronous active-low reset
//   i_sel_a     : accumulator source (RAM / immediate / ALU / hold)
//   i_sel_b     : ALU operand B (1 = RAM data, 0 = sign-extended immediate)
//   i_enb_acc   : accumulator write enable (0 holds everything)
//   i_operation : 1 = add, 0 = subtract
//   i_operand   : instruction operand field (immediate or RAM address)
//   i_ram_data  : data-RAM read data (same-cycle read)
//   o_ram_addr  : data-RAM address (combinational from i_operand)
//   o_ram_data  : data-RAM write data (combinational from accumulator)
//   o_acc       : accumulator
//   o_zero      : registered accumulator == 0
//   o_negative  : registered accumulator MSB
//   o_overflow  : registered signed overflow of last ALU write
module bip_datapath
    import bip_pkg::*;
#(
    parameter int NB_DATA       = NB_DATA_DEF,
    parameter int NB_OPERAND    = NB_OPERAND_DEF,
    parameter int NB_SELECTOR_A = NB_SELECTOR_A_DEF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NB_SELECTOR_A-1:0] i_sel_a,
    input  logic                     i_sel_b,
    input  logic                     i_enb_acc,
    input  logic                     i_operation,
    input  logic [NB_OPERAND-1:0]    i_operand,
    input  logic [NB_DATA-1:0]       i_ram_data,
    output logic [NB_OPERAND-1:0]    o_ram_addr,
    output logic [NB_DATA-1:0]       o_ram_data,
    output logic [NB_DATA-1:0]       o_acc,
    output logic                     o_zero,
    output logic                     o_negative,
    output logic                     o_overflow
);

    logic [NB_DATA-1:0] acc;
    logic               zero_q;
    logic               negative_q;
    logic               overflow_q;

    logic [NB_DATA-1:0] imm;
    logic [NB_DATA-1:0] operand_b;
    logic [NB_DATA-1:0] alu_result;
    logic               alu_overflow;
    logic [NB_DATA-1:0] acc_next;
    logic               acc_write;
    logic               overflow_next;

    assign imm = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};

    // Immediate path never looks at RAM data, so unknown RAM reads stay out.
    assign operand_b = (i_sel_b == SEL_B_RAM) ? i_ram_data : imm;

    bip_alu #(
        .NB_DATA (NB_DATA)
    ) u_alu (
        .i_a         (acc),
        .i_b         (operand_b),
        .i_operation (i_operation),
        .o_result    (alu_result),
        .o_overflow  (alu_overflow)
    );

    always_comb begin
        acc_next      = acc;
        overflow_next = 1'b0;
        acc_write     = 1'b0;
        case (i_sel_a)
            SEL_A_RAM: begin
                acc_next  = i_ram_data;
                acc_write = i_enb_acc;
            end
            SEL_A_IMM: begin
                acc_next  = imm;
                acc_write = i_enb_acc;
            end
            SEL_A_ALU: begin
                acc_next      = alu_result;
                overflow_next = alu_overflow;
                acc_write     = i_enb_acc;
            end
            default: begin
                acc_next  = acc;
                acc_write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc        <= '0;
            zero_q     <= 1'b1;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (acc_write) begin
            acc        <= acc_next;
            zero_q     <= (acc_next == '0);
            negative_q <= acc_next[NB_DATA-1];
            overflow_q <= overflow_next;
        end
    end

    assign o_ram_addr = i_operand;
    assign o_ram_data = acc;
    assign o_acc      = acc;
    assign o_zero     = zero_q;
    assign o_negative = negative_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_bip_datapath.sv
module tb_bip_datapath;

    typedef struct packed {
        logic [15:0] acc;
        logic        z;
        logic        n;
        logic        o;
    } st_t;

    logic        i_clock;
    logic        i_reset;
    logic [1:0]  i_sel_a;
    logic        i_sel_b;
    logic        i_enb_acc;
    logic        i_operation;
    logic [10:0] i_operand;
    logic [15:0] i_ram_data;
    logic [10:0] o_ram_addr;
    logic [15:0] o_ram_data;
    logic [15:0] o_acc;
    logic        o_zero;
    logic        o_negative;
    logic        o_overflow;

    st_t scb[$];
    st_t exp;
    st_t got;
    int  tests;
    int  fails;

    // bench reference model state
    logic [15:0] m_acc;
    logic        m_z, m_n, m_o;

    bip_datapath #(
        .NB_DATA       (16),
        .NB_OPERAND    (11),
        .NB_SELECTOR_A (2)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_sel_a     (i_sel_a),
        .i_sel_b     (i_sel_b),
        .i_enb_acc   (i_enb_acc),
        .i_operation (i_operation),
        .i_operand   (i_operand),
        .i_ram_data  (i_ram_data),
        .o_ram_addr  (o_ram_addr),
        .o_ram_data  (o_ram_data),
        .o_acc       (o_acc),
        .o_zero      (o_zero),
        .o_negative  (o_negative),
        .o_overflow  (o_overflow)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic drive(input logic en, input logic [1:0] sa, input logic sb,
                         input logic op, input logic [10:0] opd, input logic [15:0] ram);
        @(negedge i_clock);
        i_enb_acc   = en;
        i_sel_a     = sa;
        i_sel_b     = sb;
        i_operation = op;
        i_operand   = opd;
        i_ram_data  = ram;
    endtask

    task automatic test_reset();
        drive(1'b1, 2'b00, 1'b0, 1'b1, 11'h000, 16'h1234);
        scb.push_back('{16'h1234, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_preload: got %h expected %h", got, exp); end

        // assert reset between edges
        #2 i_reset = 1'b0;
        #1;
        scb.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_async: got %h expected %h", got, exp); end

        // a write request while reset is still low must be ignored
        drive(1'b1, 2'b01, 1'b0, 1'b0, 11'h7FF, 16'h0000);
        scb.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_held: got %h expected %h", got, exp); end

        @(negedge i_clock);
        i_reset   = 1'b1;
        i_enb_acc = 1'b0;
        scb.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL reset_release: got %h expected %h", got, exp); end
    endtask

    task automatic test_loadi();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 11'h7FF, 16'hxxxx);
        scb.push_back('{16'hFFFF, 1'b0, 1'b1, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL loadi_7ff: got %h expected %h", got, exp); end

        drive(1'b1, 2'b01, 1'b0, 1'b1, 11'h3FF, 16'hxxxx);
        scb.push_back('{16'h03FF, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL loadi_3ff: got %h expected %h", got, exp); end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 11'h010, 16'h7FFF);
        scb.push_back('{16'h7FFF, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL add_preload: got %h expected %h", got, exp); end

        drive(1'b1, 2'b10, 1'b1, 1'b1, 11'h011, 16'h0001);
        scb.push_back('{16'h8000, 1'b0, 1'b1, 1'b1});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL add_overflow: got %h expected %h", got, exp); end
    endtask

    task automatic test_load();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 11'h005, 16'h1234);
        #1; tests++;
        if (o_ram_addr !== 11'h005) begin fails++; $display("FAIL load_addr: got %h expected 005", o_ram_addr); end
        scb.push_back('{16'h1234, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL load_ovf_clear: got %h expected %h", got, exp); end
    endtask

    task automatic test_subi();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 11'h000, 16'h8000);
        scb.push_back('{16'h8000, 1'b0, 1'b1, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL subi_preload: got %h expected %h", got, exp); end

        drive(1'b1, 2'b10, 1'b0, 1'b0, 11'h001, 16'hxxxx);
        scb.push_back('{16'h7FFF, 1'b0, 1'b0, 1'b1});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL subi_overflow: got %h expected %h", got, exp); end

        drive(1'b1, 2'b01, 1'b0, 1'b0, 11'h005, 16'hxxxx);
        scb.push_back('{16'h0005, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL subi_preload5: got %h expected %h", got, exp); end

        drive(1'b1, 2'b10, 1'b0, 1'b0, 11'h005, 16'hxxxx);
        scb.push_back('{16'h0000, 1'b1, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL subi_zero: got %h expected %h", got, exp); end
    endtask

    task automatic test_hold();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 11'h0AA, 16'h0000);
        scb.push_back('{16'h00AA, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL hold_preload: got %h expected %h", got, exp); end

        drive(1'b1, 2'b11, 1'b1, 1'b1, 11'h123, 16'h5555);
        #1; tests++;
        if (o_ram_data !== 16'h00AA) begin fails++; $display("FAIL store_data: got %h expected 00aa", o_ram_data); end
        scb.push_back('{16'h00AA, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL store_hold: got %h expected %h", got, exp); end

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 1'b1, 1'b1, 11'h001, 16'h7FFF);
            scb.push_back('{16'h00AA, 1'b0, 1'b0, 1'b0});
            @(posedge i_clock); #1;
            exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
            if (got !== exp) begin fails++; $display("FAIL halt_hold[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        // acc update immediately followed by STORE must present the new value
        drive(1'b1, 2'b01, 1'b0, 1'b0, 11'h012, 16'h0000);
        scb.push_back('{16'h0012, 1'b0, 1'b0, 1'b0});
        @(posedge i_clock); #1;
        exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
        if (got !== exp) begin fails++; $display("FAIL b2b_load: got %h expected %h", got, exp); end
        drive(1'b1, 2'b11, 1'b0, 1'b0, 11'h040, 16'h0000);
        #1; tests++;
        if (o_ram_data !== 16'h0012 || o_ram_addr !== 11'h040) begin
            fails++; $display("FAIL b2b_store: got data %h addr %h expected 0012 040", o_ram_data, o_ram_addr);
        end
        @(posedge i_clock);
    endtask

    task automatic test_random();
        logic        en, sb, op;
        logic [1:0]  sa;
        logic [10:0] opd;
        logic [15:0] ram, imm, b, r;
        logic        ov;
        m_acc = 16'h0012; m_z = 1'b0; m_n = 1'b0; m_o = 1'b0;
        for (int i = 0; i < 60; i++) begin
            en  = ($urandom_range(0, 7) != 0);
            sa  = 2'($urandom_range(0, 3));
            sb  = 1'($urandom_range(0, 1));
            op  = 1'($urandom_range(0, 1));
            opd = 11'($urandom);
            ram = 16'($urandom);
            if (i % 5 == 0) ram = m_acc;
            drive(en, sa, sb, op, opd, ram);
            imm = {{5{opd[10]}}, opd};
            b   = sb ? ram : imm;
            r   = op ? (m_acc + b) : (m_acc - b);
            ov  = op ? ((m_acc[15] == b[15]) && (r[15] != m_acc[15]))
                     : ((m_acc[15] != b[15]) && (r[15] != m_acc[15]));
            if (en && sa != 2'b11) begin
                if (sa == 2'b00)      begin m_acc = ram; m_o = 1'b0; end
                else if (sa == 2'b01) begin m_acc = imm; m_o = 1'b0; end
                else                  begin m_acc = r;   m_o = ov;   end
                m_z = (m_acc == 16'h0000);
                m_n = m_acc[15];
            end
            scb.push_back('{m_acc, m_z, m_n, m_o});
            @(posedge i_clock); #1;
            exp = scb.pop_front(); got = {o_acc, o_zero, o_negative, o_overflow}; tests++;
            if (got !== exp) begin fails++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp); end
        end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        i_reset     = 1'b0;
        i_enb_acc   = 1'b0;
        i_sel_a     = 2'b11;
        i_sel_b     = 1'b0;
        i_operation = 1'b0;
        i_operand   = '0;
        i_ram_data  = '0;
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;

        test_reset();
        test_loadi();
        test_add_overflow();
        test_load();
        test_subi();
        test_hold();
        test_back_to_back();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
